passthrough_fifo: RTL and testbench
===================================

Name: passthrough_fifo

Overview:
- Ready/valid elastic buffer that sits directly downstream of the 10-bit passthrough stage and consumes its io_out word stream.
- It decouples the producer from a back-pressuring consumer by holding up to DEPTH words in order, and reports its occupancy.
- It also provides the flow-control handshake that the passthrough stage itself lacks.

Parameters:
- WIDTH, 10, data word width in bits; matches the passthrough stage.
- DEPTH, 4, number of storage entries; must be a power of two and ≥ 2.
- CW, log2(DEPTH)+1 (derived, not overridable), width of io_count.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset: 0 = in reset.
- io_in_valid  input  1  upstream word present on io_in_bits.
- io_in_ready  output  1  FIFO can accept a word this cycle.
- io_in_bits  input  WIDTH  upstream data word.
- io_out_valid  output  1  head word available on io_out_bits.
- io_out_ready  input  1  downstream accepts the head word this cycle.
- io_out_bits  output  WIDTH  head-of-queue data word.
- io_count  output  CW  number of words currently stored (0..DEPTH).

Behaviour:
- State: storage array mem[DEPTH] of WIDTH bits, wr_ptr and rd_ptr (log2(DEPTH) bits each, natural wrap-around), count (CW bits).
- Reset: reset low asynchronously clears wr_ptr, rd_ptr, count and every mem entry to 0. This holds at any time, including mid-transfer; stored words are discarded.
- Outputs during reset: io_in_ready=0, io_out_valid=0, io_out_bits=0, io_count=0.
- Outputs are functions of registered state only; there is no combinational in-to-out path. The single exception is io_in_ready, which is also gated by reset.
- io_in_ready = (count != DEPTH) and reset high.
- io_out_valid = (count != 0).
- io_out_bits = mem[rd_ptr] when count != 0, else 0.
- io_count = count.
- push = io_in_valid and io_in_ready. On push: mem[wr_ptr] <= io_in_bits, wr_ptr <= wr_ptr+1.
- pop = io_out_valid and io_out_ready. On pop: rd_ptr <= rd_ptr+1.
- Count update: count <= count + push - pop.
- Latency: a word pushed at edge N appears on io_out_bits with io_out_valid=1 after edge N (one-cycle minimum in-to-out latency). There is no bypass when empty.
- Full (count=DEPTH): io_in_ready=0 even if io_out_ready=1 in the same cycle, so a full FIFO cannot push and pop together. io_in_valid while not ready is ignored; no state change and no data loss in the FIFO (the producer must hold).
- Empty (count=0): a pop request (io_out_ready=1) is ignored. A simultaneous push proceeds; count goes to 1.
- Simultaneous push and pop with 0 < count < DEPTH: both pointers advance and count is unchanged.
- Pointer wrap: after DEPTH pushes wr_ptr returns to 0; ordering is strictly FIFO across the wrap.
- io_out_bits/io_out_valid are stable while io_out_valid=1 and io_out_ready=0. The head word does not change until popped.
- No X on any output after reset release.

Test Plan:
1. Reset then idle: reset=0 for 3 cycles with io_in_valid=1, bits=0x3FF, then release. Require io_in_ready=0 and io_count=0 during reset. After release: io_count=0, io_out_valid=0, io_out_bits=0, io_in_ready=1.
2. Fill and drain: push 0x001,0x002,0x003,0x004 on consecutive cycles with io_out_ready=0. Require io_count to step 1,2,3,4, then io_in_ready=0. A fifth push of 0x005 is ignored (count stays 4). Then io_out_ready=1 for 4 cycles; require out sequence 0x001..0x004, count stepping back to 0, and io_out_valid=0 after.
3. Streaming: io_in_valid=1 and io_out_ready=1 continuously with bits incrementing from 0x100. Require first output the cycle after the first push, then one word per cycle in order, with io_count held at 1.
4. Wrap-around: run 10 push/pop cycles with DEPTH=4, interleaving two pushes per pop until full, then draining. Require output order exactly equal to input order across pointer wrap, with no duplicates or drops.
5. Full with simultaneous pop: with count=4, drive io_in_valid=1 (0x2AA) and io_out_ready=1. Require the head popped, the push rejected, and count=3. Next cycle the push of 0x2AA is accepted and count=3.
6. Reset mid-operation: with count=3, assert reset asynchronously between edges. Require io_out_valid and io_count to drop to 0 immediately. After release the FIFO is empty and the old words never appear.

Source files
------------

// File: rtl/passthrough_fifo.sv
// Ready/valid elastic buffer holding up to DEPTH words in order behind the 10-bit passthrough stage.
// All outputs come from registered state; only io_in_ready is additionally gated by reset.
module passthrough_fifo #(
  parameter  int WIDTH = 10,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_in_bits,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_out_bits,
  output logic [CW-1:0]    io_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // A full FIFO refuses input even when the head is popped in the same cycle.
  assign io_in_ready  = !w_full && reset;
  assign io_out_valid = !w_empty;
  assign io_out_bits  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign io_count     = r_count;

  assign w_push = io_in_valid && io_in_ready;
  assign w_pop  = io_out_valid && io_out_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= io_in_bits;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_passthrough_fifo.sv
// Scoreboard bench for passthrough_fifo: a queue model updated from observed handshakes,
// checked every cycle on the falling edge against the DUT outputs.
module tb_passthrough_fifo;

  localparam int WIDTH = 10;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clock;
  logic             reset;
  logic             io_in_valid;
  logic             io_in_ready;
  logic [WIDTH-1:0] io_in_bits;
  logic             io_out_valid;
  logic             io_out_ready;
  logic [WIDTH-1:0] io_out_bits;
  logic [CW-1:0]    io_count;

  int n_tests = 0;
  int n_fail  = 0;
  logic [WIDTH-1:0] model_q[$];

  passthrough_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .io_in_valid  (io_in_valid),
    .io_in_ready  (io_in_ready),
    .io_in_bits   (io_in_bits),
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready),
    .io_out_bits  (io_out_bits),
    .io_count     (io_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard: compare against the reference queue, then apply this cycle's handshakes.
  always @(negedge clock) begin
    int sz;
    logic [WIDTH-1:0] head;
    if (!reset) begin
      check("rst_in_ready", 32'(io_in_ready), 32'(0));
      check("rst_out_valid", 32'(io_out_valid), 32'(0));
      check("rst_count", 32'(io_count), 32'(0));
      check("rst_out_bits", 32'(io_out_bits), 32'(0));
      model_q.delete();
    end else begin
      sz   = model_q.size();
      head = (sz != 0) ? model_q[0] : '0;
      check("in_ready", 32'(io_in_ready), 32'(sz != DEPTH));
      check("out_valid", 32'(io_out_valid), 32'(sz != 0));
      check("count", 32'(io_count), 32'(sz));
      check("out_bits", 32'(io_out_bits), 32'(head));
      if (sz != 0 && io_out_ready) begin
        $display("[TB] pop  %03h (count before %0d)", head, sz);
        void'(model_q.pop_front());
      end
      if (sz != DEPTH && io_in_valid) begin
        $display("[TB] push %03h (count before %0d)", io_in_bits, sz);
        model_q.push_back(io_in_bits);
      end
    end
  end

  task automatic step(input logic v, input logic [WIDTH-1:0] b, input logic r);
    @(posedge clock);
    #1;
    io_in_valid  = v;
    io_in_bits   = b;
    io_out_ready = r;
  endtask

  initial begin
    // 1: reset with a pending input word, then idle
    reset        = 1'b0;
    io_in_valid  = 1'b1;
    io_in_bits   = 10'h3FF;
    io_out_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset       = 1'b1;
    io_in_valid = 1'b0;
    io_in_bits  = '0;
    step(1'b0, '0, 1'b0);

    // 2: fill, rejected fifth push, drain
    for (int i = 1; i <= 5; i++) step(1'b1, WIDTH'(i), 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);

    // 3: streaming
    for (int i = 0; i < 12; i++) step(1'b1, WIDTH'(10'h100 + i), 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);

    // 4: wrap-around, two pushes per pop until full, then drain
    for (int i = 0; i < 10; i++) step(1'b1, WIDTH'(10'h200 + i), (i % 2) == 1);
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);

    // 5: full with simultaneous pop
    for (int i = 0; i < 4; i++) step(1'b1, WIDTH'(10'h050 + i), 1'b0);
    step(1'b1, 10'h2AA, 1'b1);
    step(1'b1, 10'h2AA, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);

    // 6: asynchronous reset between edges with three words stored
    for (int i = 0; i < 3; i++) step(1'b1, WIDTH'(10'h0E0 + i), 1'b0);
    step(1'b0, '0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check("async_out_valid", 32'(io_out_valid), 32'(0));
    check("async_count", 32'(io_count), 32'(0));
    check("async_in_ready", 32'(io_in_ready), 32'(0));
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), WIDTH'($urandom), ($urandom_range(0, 3) != 0) ^ (i >= 200));
    end
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);
    @(posedge clock);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
